// File: rtl/regfile_writeback_arbiter_if.sv
// Register-file writeback bus between the producers and the writeback arbiter.
//   pipe_valid/pipe_reg/pipe_data : in-order pipeline writeback request
//   md_valid/md_reg/md_data       : mult/div result offer, md_ready back-pressure
//   ctrl_writeEnable/ctrl_writeReg/data_writeReg : registered regfile write port
//   pending_mask                  : registers with a live queued mult/div result
//   fifo_count                    : mult/div FIFO occupancy (squashed entries included)
// master = producer / regfile side, slave = arbiter.
interface regfile_writeback_arbiter_if #(
    parameter int CW = 3
);
    logic          pipe_valid;
    logic [4:0]    pipe_reg;
    logic [31:0]   pipe_data;
    logic          md_valid;
    logic [4:0]    md_reg;
    logic [31:0]   md_data;
    logic          md_ready;
    logic          ctrl_writeEnable;
    logic [4:0]    ctrl_writeReg;
    logic [31:0]   data_writeReg;
    logic [31:0]   pending_mask;
    logic [CW-1:0] fifo_count;

    modport master (
        output pipe_valid, pipe_reg, pipe_data, md_valid, md_reg, md_data,
        input  md_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg,
               pending_mask, fifo_count
    );

    modport slave (
        input  pipe_valid, pipe_reg, pipe_data, md_valid, md_reg, md_data,
        output md_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg,
               pending_mask, fifo_count
    );
endinterface

// File: rtl/regfile_writeback_arbiter.sv
// Merges pipeline writebacks (priority, never stalled) and buffered mult/div
// results onto the single register-file write port.
//   clock      : system clock, rising edge
//   ctrl_reset : asynchronous active-low reset
//   bus        : regfile_writeback_arbiter_if.slave (requests, regfile write
//                controls, pending mask, FIFO occupancy)
// Parameters: DEPTH = FIFO entries (power of two, 2..16), CW = log2(DEPTH)+1.
module regfile_writeback_arbiter #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input logic clock,
    input logic ctrl_reset,
    regfile_writeback_arbiter_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic [4:0]       mem_reg  [DEPTH];
    logic [31:0]      mem_data [DEPTH];
    logic [DEPTH-1:0] live;
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic [CW-1:0]    count;

    logic full;
    logic empty;
    logic pipe_wr;
    logic push;
    logic pop;
    logic md_live;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign pipe_wr = bus.pipe_valid && (bus.pipe_reg != 5'd0);
    // A transfer to r0 is consumed but never stored.
    assign push    = bus.md_valid && !full && (bus.md_reg != 5'd0);
    assign pop     = !pipe_wr && !empty;
    // Pipeline write in the same edge is newer than the arriving md result.
    assign md_live = !(pipe_wr && (bus.md_reg == bus.pipe_reg));

    assign bus.md_ready   = !full;
    assign bus.fifo_count = count;

    // Payload storage needs no reset; validity is carried by count and live.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_reg[tail]  <= bus.md_reg;
            mem_data[tail] <= bus.md_data;
        end
    end

    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            live  <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            // Later assignments win: squash, then pop, then the new tail entry.
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (pipe_wr && (mem_reg[i] == bus.pipe_reg)) begin
                    live[i] <= 1'b0;
                end
            end
            if (pop) begin
                live[head] <= 1'b0;
                head       <= head + AW'(1);
            end
            if (push) begin
                live[tail] <= md_live;
                tail       <= tail + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            bus.ctrl_writeEnable <= 1'b0;
            bus.ctrl_writeReg    <= '0;
            bus.data_writeReg    <= '0;
        end else if (pipe_wr) begin
            bus.ctrl_writeEnable <= 1'b1;
            bus.ctrl_writeReg    <= bus.pipe_reg;
            bus.data_writeReg    <= bus.pipe_data;
        end else if (pop && live[head]) begin
            bus.ctrl_writeEnable <= 1'b1;
            bus.ctrl_writeReg    <= mem_reg[head];
            bus.data_writeReg    <= mem_data[head];
        end else begin
            // Idle or squashed-head pop: address and data hold.
            bus.ctrl_writeEnable <= 1'b0;
        end
    end

    always_comb begin
        bus.pending_mask = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (live[i]) begin
                bus.pending_mask[mem_reg[i]] = 1'b1;
            end
        end
        bus.pending_mask[0] = 1'b0;
    end
endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
module tb_regfile_writeback_arbiter;
    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } wr_t;

    logic clock;
    logic ctrl_reset;
    int   n_vec;
    int   n_fail;
    wr_t  exp_q[$];

    regfile_writeback_arbiter_if #(.CW(3)) bus ();

    regfile_writeback_arbiter #(.DEPTH(4), .CW(3)) dut (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .bus        (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_wr(input logic [4:0] r, input logic [31:0] d);
        wr_t w;
        w.r = r;
        w.d = d;
        exp_q.push_back(w);
    endtask

    // Scoreboard: every regfile write must match the next expected write.
    always @(posedge clock) begin
        #1;
        if (ctrl_reset && bus.ctrl_writeEnable) begin
            if (exp_q.size() == 0) begin
                check("spurious_write", {27'd0, bus.ctrl_writeReg}, 32'd0);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                check("write_reg", {27'd0, bus.ctrl_writeReg}, {27'd0, w.r});
                check("write_data", bus.data_writeReg, w.d);
            end
        end
    end

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && (exp_q.size() != 0 || bus.fifo_count != 3'd0); i++)
            @(negedge clock);
        @(negedge clock);
        check({tag, "_drain_q"}, exp_q.size(), 0);
        check({tag, "_drain_count"}, {29'd0, bus.fifo_count}, 32'd0);
    endtask

    initial begin
        int  idx;
        logic rdy;
        n_vec  = 0;
        n_fail = 0;
        bus.pipe_valid = 1'b0; bus.pipe_reg = '0; bus.pipe_data = '0;
        bus.md_valid   = 1'b0; bus.md_reg   = '0; bus.md_data   = '0;
        ctrl_reset = 1'b1;
        #1 ctrl_reset = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_we",    {31'd0, bus.ctrl_writeEnable}, 32'd0);
        check("rst_reg",   {27'd0, bus.ctrl_writeReg}, 32'd0);
        check("rst_data",  bus.data_writeReg, 32'd0);
        check("rst_mask",  bus.pending_mask, 32'd0);
        check("rst_count", {29'd0, bus.fifo_count}, 32'd0);
        check("rst_ready", {31'd0, bus.md_ready}, 32'd1);
        ctrl_reset = 1'b1;
        @(negedge clock);

        // Pipeline priority over a queued md result.
        bus.pipe_valid = 1'b1; bus.pipe_reg = 5'd3; bus.pipe_data = 32'h33;
        bus.md_valid = 1'b1; bus.md_reg = 5'd5; bus.md_data = 32'hAAAA0005;
        repeat (3) expect_wr(5'd3, 32'h33);
        expect_wr(5'd5, 32'hAAAA0005);
        @(negedge clock);
        bus.md_valid = 1'b0;
        check("prio_latency_we", {31'd0, bus.ctrl_writeEnable}, 32'd1);
        check("prio_count", {29'd0, bus.fifo_count}, 32'd1);
        check("prio_mask5_a", {31'd0, bus.pending_mask[5]}, 32'd1);
        @(negedge clock);
        check("prio_mask5_b", {31'd0, bus.pending_mask[5]}, 32'd1);
        @(negedge clock);
        check("prio_mask5_c", {31'd0, bus.pending_mask[5]}, 32'd1);
        bus.pipe_valid = 1'b0;
        @(negedge clock);
        check("prio_mask_after_pop", bus.pending_mask, 32'd0);
        check("prio_count_after_pop", {29'd0, bus.fifo_count}, 32'd0);
        drain("prio");

        // Full / back-pressure with the pipeline busy.
        bus.pipe_valid = 1'b1; bus.pipe_reg = 5'd9; bus.pipe_data = 32'h99;
        bus.md_valid = 1'b1;
        idx = 1;
        for (int c = 0; c < 6; c++) begin
            bus.md_reg = 5'(idx); bus.md_data = 32'h100 + 32'(idx);
            rdy = bus.md_ready;
            expect_wr(5'd9, 32'h99);
            @(negedge clock);
            if (rdy) idx++;
        end
        check("full_accepted", idx, 5);
        check("full_count", {29'd0, bus.fifo_count}, 32'd4);
        check("full_ready", {31'd0, bus.md_ready}, 32'd0);
        for (int k = 1; k <= 6; k++) expect_wr(5'(k), 32'h100 + 32'(k));
        bus.pipe_valid = 1'b0;
        for (int c = 0; c < 20 && idx <= 6; c++) begin
            bus.md_reg = 5'(idx); bus.md_data = 32'h100 + 32'(idx);
            rdy = bus.md_ready;
            @(negedge clock);
            if (rdy) idx++;
        end
        bus.md_valid = 1'b0;
        check("full_all_accepted", idx, 7);
        drain("full");

        // Squash: pipeline write to r7 kills the queued r7 result.
        bus.pipe_valid = 1'b1; bus.pipe_reg = 5'd10; bus.pipe_data = 32'hA0;
        bus.md_valid = 1'b1; bus.md_reg = 5'd7; bus.md_data = 32'h7;
        expect_wr(5'd10, 32'hA0);
        expect_wr(5'd10, 32'hA0);
        expect_wr(5'd7, 32'h70);
        expect_wr(5'd8, 32'h8);
        @(negedge clock);
        bus.md_reg = 5'd8; bus.md_data = 32'h8;
        @(negedge clock);
        bus.md_valid = 1'b0;
        bus.pipe_reg = 5'd7; bus.pipe_data = 32'h70;
        check("sq_mask_before", bus.pending_mask, 32'h0000_0180);
        @(negedge clock);
        bus.pipe_valid = 1'b0;
        check("sq_mask_after", bus.pending_mask, 32'h0000_0100);
        check("sq_count", {29'd0, bus.fifo_count}, 32'd2);
        @(negedge clock);
        check("sq_no_write", {31'd0, bus.ctrl_writeEnable}, 32'd0);
        check("sq_count_pop", {29'd0, bus.fifo_count}, 32'd1);
        drain("sq");

        // Same-edge squash of the arriving md entry.
        bus.pipe_valid = 1'b1; bus.pipe_reg = 5'd11; bus.pipe_data = 32'hB0;
        bus.md_valid = 1'b1; bus.md_reg = 5'd11; bus.md_data = 32'hB1;
        expect_wr(5'd11, 32'hB0);
        @(negedge clock);
        bus.pipe_valid = 1'b0; bus.md_valid = 1'b0;
        check("same_edge_mask", bus.pending_mask, 32'd0);
        check("same_edge_count", {29'd0, bus.fifo_count}, 32'd1);
        drain("same_edge");

        // Register 0 from both sources.
        bus.pipe_valid = 1'b1; bus.pipe_reg = 5'd0; bus.pipe_data = 32'hDEAD;
        bus.md_valid = 1'b1; bus.md_reg = 5'd0; bus.md_data = 32'hBEEF;
        @(negedge clock);
        bus.pipe_valid = 1'b0; bus.md_valid = 1'b0;
        check("r0_we", {31'd0, bus.ctrl_writeEnable}, 32'd0);
        check("r0_count", {29'd0, bus.fifo_count}, 32'd0);
        check("r0_mask", bus.pending_mask, 32'd0);
        check("r0_ready", {31'd0, bus.md_ready}, 32'd1);

        // Back-to-back md stream across pointer wrap.
        bus.md_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.md_reg = 5'(16 + i); bus.md_data = 32'hD000_0000 + 32'(i);
            expect_wr(5'(16 + i), 32'hD000_0000 + 32'(i));
            @(negedge clock);
            check("wrap_count", {29'd0, bus.fifo_count}, 32'd1);
            check("wrap_we", {31'd0, bus.ctrl_writeEnable}, (i > 0) ? 32'd1 : 32'd0);
        end
        bus.md_valid = 1'b0;
        @(negedge clock);
        check("wrap_last_we", {31'd0, bus.ctrl_writeEnable}, 32'd1);
        check("wrap_empty", {29'd0, bus.fifo_count}, 32'd0);
        drain("wrap");

        // Reset mid-traffic with two queued entries.
        bus.pipe_valid = 1'b1; bus.pipe_reg = 5'd12; bus.pipe_data = 32'hC0;
        bus.md_valid = 1'b1; bus.md_reg = 5'd13; bus.md_data = 32'hD13;
        expect_wr(5'd12, 32'hC0);
        expect_wr(5'd12, 32'hC0);
        @(negedge clock);
        bus.md_reg = 5'd14; bus.md_data = 32'hD14;
        @(negedge clock);
        check("pre_rst_count", {29'd0, bus.fifo_count}, 32'd2);
        bus.pipe_valid = 1'b0; bus.md_valid = 1'b0;
        ctrl_reset = 1'b0;
        repeat (3) @(negedge clock);
        ctrl_reset = 1'b1;
        @(negedge clock);
        check("mid_rst_we",    {31'd0, bus.ctrl_writeEnable}, 32'd0);
        check("mid_rst_reg",   {27'd0, bus.ctrl_writeReg}, 32'd0);
        check("mid_rst_data",  bus.data_writeReg, 32'd0);
        check("mid_rst_count", {29'd0, bus.fifo_count}, 32'd0);
        check("mid_rst_mask",  bus.pending_mask, 32'd0);
        check("mid_rst_ready", {31'd0, bus.md_ready}, 32'd1);
        repeat (4) @(negedge clock);
        check("mid_rst_no_write", {31'd0, bus.ctrl_writeEnable}, 32'd0);
        check("final_q_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
